// File: rtl/bus_bit_share_arbiter.sv
// Per-bit two-sink arbiter: each bit of source_bus is routed to sink A or B
// under round-robin tie-break with bounded hold time on contended bits.
module bus_bit_share_arbiter #(
    parameter int unsigned WIDTH    = 2,
    parameter int unsigned HOLD_MAX = 15,
    parameter int unsigned CNT_W    = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] source_bus,
    input  logic [WIDTH-1:0] req_a,
    input  logic [WIDTH-1:0] req_b,
    output logic [WIDTH-1:0] grant_a,
    output logic [WIDTH-1:0] grant_b,
    output logic [WIDTH-1:0] sink_bus_a,
    output logic [WIDTH-1:0] sink_bus_b,
    output logic [7:0]       conflict_cnt
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        OWN_A = 2'd1,
        OWN_B = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] HOLD_LIM = CNT_W'(HOLD_MAX);
    localparam bit               PREEMPT  = (HOLD_MAX != 0);

    state_t           state_q [WIDTH];
    state_t           state_d [WIDTH];
    logic [CNT_W-1:0] hold_q  [WIDTH];
    logic [CNT_W-1:0] hold_d  [WIDTH];
    logic [WIDTH-1:0] prio_q;
    logic [WIDTH-1:0] prio_d;
    logic [WIDTH-1:0] contend;

    // prio bit 0 means A wins the next tie, 1 means B wins.
    always_comb begin
        prio_d  = prio_q;
        contend = '0;
        for (int unsigned i = 0; i < WIDTH; i++) begin
            state_d[i] = state_q[i];
            hold_d[i]  = hold_q[i];
            unique case (state_q[i])
                IDLE: begin
                    if (req_a[i] && req_b[i]) begin
                        contend[i] = 1'b1;
                        state_d[i] = prio_q[i] ? OWN_B : OWN_A;
                        prio_d[i]  = ~prio_q[i];
                    end else if (req_a[i]) begin
                        state_d[i] = OWN_A;
                    end else if (req_b[i]) begin
                        state_d[i] = OWN_B;
                    end
                end
                OWN_A: begin
                    if (!req_a[i]) begin
                        state_d[i] = req_b[i] ? OWN_B : IDLE;
                    end else if (req_b[i] && PREEMPT && hold_q[i] == HOLD_LIM) begin
                        contend[i] = 1'b1;
                        state_d[i] = OWN_B;
                        prio_d[i]  = 1'b0;
                    end
                end
                OWN_B: begin
                    if (!req_b[i]) begin
                        state_d[i] = req_a[i] ? OWN_A : IDLE;
                    end else if (req_a[i] && PREEMPT && hold_q[i] == HOLD_LIM) begin
                        contend[i] = 1'b1;
                        state_d[i] = OWN_A;
                        prio_d[i]  = 1'b1;
                    end
                end
                default: state_d[i] = IDLE;
            endcase

            // Any owner change (including a same-edge handover) restarts the hold count.
            if (state_d[i] == IDLE) begin
                hold_d[i] = '0;
            end else if (state_d[i] != state_q[i]) begin
                hold_d[i] = CNT_W'(1);
            end else if (hold_q[i] < HOLD_LIM) begin
                hold_d[i] = hold_q[i] + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < WIDTH; i++) begin
                state_q[i] <= IDLE;
                hold_q[i]  <= '0;
            end
            prio_q       <= '0;
            grant_a      <= '0;
            grant_b      <= '0;
            sink_bus_a   <= '0;
            sink_bus_b   <= '0;
            conflict_cnt <= '0;
        end else begin
            for (int unsigned i = 0; i < WIDTH; i++) begin
                state_q[i]    <= state_d[i];
                hold_q[i]     <= hold_d[i];
                grant_a[i]    <= (state_d[i] == OWN_A);
                grant_b[i]    <= (state_d[i] == OWN_B);
                sink_bus_a[i] <= (state_d[i] == OWN_A) ? source_bus[i] : 1'b0;
                sink_bus_b[i] <= (state_d[i] == OWN_B) ? source_bus[i] : 1'b0;
            end
            prio_q <= prio_d;
            if (|contend && conflict_cnt != 8'hFF) begin
                conflict_cnt <= conflict_cnt + 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_bus_bit_share_arbiter.sv
// Scoreboard bench for bus_bit_share_arbiter: two instances (HOLD_MAX=3 and 1)
// share stimulus; a behavioural model queues expected outputs per edge.
module tb_bus_bit_share_arbiter;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [1:0] source_bus, req_a, req_b;

    logic [1:0] ga3, gb3, sa3, sb3, ga1, gb1, sa1, sb1;
    logic [7:0] cc3, cc1;

    always #5 clk = ~clk;

    bus_bit_share_arbiter #(.WIDTH(2), .HOLD_MAX(3), .CNT_W(2)) u_h3 (
        .clk(clk), .rst_n(rst_n), .source_bus(source_bus),
        .req_a(req_a), .req_b(req_b),
        .grant_a(ga3), .grant_b(gb3),
        .sink_bus_a(sa3), .sink_bus_b(sb3),
        .conflict_cnt(cc3)
    );

    bus_bit_share_arbiter #(.WIDTH(2), .HOLD_MAX(1), .CNT_W(1)) u_h1 (
        .clk(clk), .rst_n(rst_n), .source_bus(source_bus),
        .req_a(req_a), .req_b(req_b),
        .grant_a(ga1), .grant_b(gb1),
        .sink_bus_a(sa1), .sink_bus_b(sb1),
        .conflict_cnt(cc1)
    );

    typedef struct {
        logic [15:0] e3;
        logic [15:0] e1;
    } exp_t;

    exp_t q[$];
    int   n_vec = 0;
    int   n_err = 0;

    // Model state per instance k (0: HOLD_MAX=3, 1: HOLD_MAX=1), per bit b.
    // Owner: 0 none, 1 A, 2 B. age = cycles of grant so far for current owner.
    int m_own [2][2];
    int m_age [2][2];
    int m_pb  [2][2];   // 1 => B wins next tie
    int m_cnt [2];

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s @%0t: got %0h, expected %0h", tag, $time, got, exp);
        end
    endtask

    function automatic logic [15:0] model_step(input int k, input logic [1:0] ra,
                                               input logic [1:0] rb, input logic [1:0] src,
                                               input logic rst);
        int         h;
        bit         hit;
        logic [1:0] ga, gb;
        h   = (k == 0) ? 3 : 1;
        hit = 0;
        ga  = 2'b00;
        gb  = 2'b00;
        if (!rst) begin
            for (int b = 0; b < 2; b++) begin
                m_own[k][b] = 0;
                m_age[k][b] = 0;
                m_pb[k][b]  = 0;
            end
            m_cnt[k] = 0;
            return 16'h0000;
        end
        for (int b = 0; b < 2; b++) begin
            int own, nxt;
            own = m_own[k][b];
            nxt = own;
            if (own == 0) begin
                if (ra[b] && rb[b]) begin
                    hit = 1;
                    nxt = (m_pb[k][b] != 0) ? 2 : 1;
                    m_pb[k][b] = (nxt == 1) ? 1 : 0;
                end else if (ra[b]) nxt = 1;
                else if (rb[b]) nxt = 2;
            end else begin
                bit mine, other;
                mine  = (own == 1) ? ra[b] : rb[b];
                other = (own == 1) ? rb[b] : ra[b];
                if (!mine) nxt = other ? 3 - own : 0;
                else if (other && m_age[k][b] == h) begin
                    hit = 1;
                    nxt = 3 - own;
                    m_pb[k][b] = (own == 1) ? 0 : 1;
                end
            end
            if (nxt == 0) m_age[k][b] = 0;
            else if (nxt != own) m_age[k][b] = 1;
            else if (m_age[k][b] < h) m_age[k][b]++;
            m_own[k][b] = nxt;
            ga[b] = (nxt == 1);
            gb[b] = (nxt == 2);
        end
        if (hit && m_cnt[k] < 255) m_cnt[k]++;
        return {ga, gb, ga & src, gb & src, 8'(m_cnt[k])};
    endfunction

    task automatic step(input logic [1:0] ra, input logic [1:0] rb,
                        input logic [1:0] src, input logic rst);
        exp_t e, p;
        req_a      = ra;
        req_b      = rb;
        source_bus = src;
        rst_n      = rst;
        e.e3 = model_step(0, ra, rb, src, rst);
        e.e1 = model_step(1, ra, rb, src, rst);
        q.push_back(e);
        @(posedge clk);
        #1;
        p = q.pop_front();
        check("h3.grant_a",  {6'd0, ga3}, {6'd0, p.e3[15:14]});
        check("h3.grant_b",  {6'd0, gb3}, {6'd0, p.e3[13:12]});
        check("h3.sink_a",   {6'd0, sa3}, {6'd0, p.e3[11:10]});
        check("h3.sink_b",   {6'd0, sb3}, {6'd0, p.e3[9:8]});
        check("h3.conflict", cc3,         p.e3[7:0]);
        check("h3.excl",     {7'd0, |(ga3 & gb3)}, 8'd0);
        check("h1.grant_a",  {6'd0, ga1}, {6'd0, p.e1[15:14]});
        check("h1.grant_b",  {6'd0, gb1}, {6'd0, p.e1[13:12]});
        check("h1.sink_a",   {6'd0, sa1}, {6'd0, p.e1[11:10]});
        check("h1.sink_b",   {6'd0, sb1}, {6'd0, p.e1[9:8]});
        check("h1.conflict", cc1,         p.e1[7:0]);
    endtask

    initial begin
        req_a      = 2'b11;
        req_b      = 2'b11;
        source_bus = 2'b11;
        rst_n      = 1'b0;
        @(posedge clk);
        #1;

        // Reset with all requests high
        step(2'b11, 2'b11, 2'b11, 1'b0);
        step(2'b11, 2'b11, 2'b11, 1'b0);

        // Split routing, then data change
        step(2'b10, 2'b01, 2'b11, 1'b1);
        step(2'b10, 2'b01, 2'b01, 1'b1);
        step(2'b10, 2'b01, 2'b10, 1'b1);

        // Round-robin tie on bit 0
        step(2'b00, 2'b00, 2'b00, 1'b0);
        step(2'b01, 2'b01, 2'b11, 1'b1);
        step(2'b00, 2'b00, 2'b11, 1'b1);
        step(2'b01, 2'b01, 2'b11, 1'b1);

        // Preemption on bit 0: A alone, then continuous contention
        step(2'b00, 2'b00, 2'b00, 1'b0);
        step(2'b01, 2'b00, 2'b01, 1'b1);
        for (int i = 0; i < 10; i++) step(2'b01, 2'b01, 2'($urandom_range(0, 3)), 1'b1);

        // Handover on bit 1, then idle
        step(2'b00, 2'b00, 2'b00, 1'b0);
        step(2'b10, 2'b10, 2'b10, 1'b1);
        step(2'b10, 2'b00, 2'b10, 1'b1);
        step(2'b00, 2'b10, 2'b10, 1'b1);
        step(2'b00, 2'b10, 2'b00, 1'b1);
        step(2'b00, 2'b00, 2'b11, 1'b1);

        // Random traffic with occasional mid-operation reset
        for (int i = 0; i < 60; i++)
            step(2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
                 2'($urandom_range(0, 3)), ($urandom_range(0, 19) != 0));

        // Saturation under permanent contention, then mid-op reset
        step(2'b00, 2'b00, 2'b00, 1'b0);
        for (int i = 0; i < 300; i++) step(2'b11, 2'b11, 2'($urandom_range(0, 3)), 1'b1);
        step(2'b11, 2'b11, 2'b11, 1'b0);
        step(2'b11, 2'b11, 2'b11, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
